// File: rtl/autotune_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : autotune_pkg                                           |
// | Description : Shared types and defaults for the autotune frame path. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package autotune_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ANALYZE = 2'd1,
    SYNTH   = 2'd2
  } frame_state_t;

  // Width of the pitch period passed from yin to psola
  localparam int PERIOD_W = 11;

  // Default analysis window length in samples
  localparam int WINDOW_SIZE_DEFAULT = 2048;

endpackage
`default_nettype wire

// File: rtl/frame_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_fill_ctrl                                        |
// | Description : Ping-pong window fill: index counter, bank toggle,     |
// |               registered write port and bank-full strobe.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_fill_ctrl
  import autotune_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = WINDOW_SIZE_DEFAULT,
  localparam int AW         = $clog2(WINDOW_SIZE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             valid_in,
  input  logic             swap_in,       // hand the current fill bank to the reader
  output logic             wr_en_out,
  output logic [AW:0]      wr_addr_out,
  output logic [WIDTH-1:0] wr_data_out,
  output logic             bank_full_out, // one cycle, aligned with the last write
  output logic             fill_bank_out
);

  logic             fill_bank_q, fill_bank_d;
  logic [AW-1:0]    index_q, index_d;
  logic             wr_en_q, wr_en_d;
  logic [AW:0]      wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             full_q, full_d;
  logic             bank_eff;

  // Next-state of the write port; a sample arriving in the swap cycle already lands in the new bank
  always_comb begin
    bank_eff    = fill_bank_q ^ swap_in;
    fill_bank_d = bank_eff;
    index_d     = index_q;
    wr_en_d     = valid_in;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    full_d      = 1'b0;
    if (valid_in) begin
      wr_addr_d = {bank_eff, index_q};
      wr_data_d = sample_in;
      index_d   = index_q + 1'b1;
      full_d    = (index_q == AW'(WINDOW_SIZE - 1));
    end
  end

  // Write-port and counter registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fill_bank_q <= 1'b0;
      index_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      full_q      <= 1'b0;
    end else begin
      fill_bank_q <= fill_bank_d;
      index_q     <= index_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      full_q      <= full_d;
    end
  end

  assign wr_en_out     = wr_en_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign bank_full_out = full_q;
  assign fill_bank_out = fill_bank_q;

endmodule
`default_nettype wire

// File: rtl/pitch_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pitch_frame_scheduler                                  |
// | Description : Frame sequencer between the mic stream and yin/psola:  |
// |               fills ping-pong banks, runs analysis then synthesis,   |
// |               tracks overruns and timeouts.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pitch_frame_scheduler
  import autotune_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = WINDOW_SIZE_DEFAULT,
  parameter int MIN_PERIOD  = 20,
  parameter int TIMEOUT     = 2**20,
  localparam int AW         = $clog2(WINDOW_SIZE)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [WIDTH-1:0]    sample_in,
  input  logic                valid_in,
  output logic                wr_en_out,
  output logic [AW:0]         wr_addr_out,
  output logic [WIDTH-1:0]    wr_data_out,
  output logic                rd_bank_out,
  output logic                yin_start_out,
  input  logic                yin_valid_in,
  input  logic [PERIOD_W-1:0] taumin_in,
  output logic                psola_start_out,
  output logic [PERIOD_W-1:0] period_out,
  input  logic                psola_done_in,
  output logic                frame_done_out,
  output logic                unvoiced_out,
  output logic                overrun_out,
  output logic                timeout_out,
  output logic [15:0]         frame_count_out
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_ANALYZE = 2'(ANALYZE);
  localparam logic [1:0] ST_SYNTH   = 2'(SYNTH);

  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                rd_bank_q, rd_bank_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                yin_start_q, yin_start_d;
  logic                psola_start_q, psola_start_d;
  logic                frame_done_q, frame_done_d;
  logic                unvoiced_q, unvoiced_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         count_q, count_d;

  logic                bank_full;
  logic                fill_bank;
  logic                bank_swap;
  logic                timer_expired;

  frame_fill_ctrl #(
    .WIDTH       (WIDTH),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_fill (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sample_in     (sample_in),
    .valid_in      (valid_in),
    .swap_in       (bank_swap),
    .wr_en_out     (wr_en_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .bank_full_out (bank_full),
    .fill_bank_out (fill_bank)
  );

  // Frame FSM; the swap decision looks only at registered state, so a bank
  // filling on the cycle the FSM heads back to IDLE counts as an overrun
  always_comb begin
    state_d       = state_q;
    timer_d       = (state_q == ST_IDLE) ? '0 : timer_q + 1'b1;
    rd_bank_d     = rd_bank_q;
    period_d      = period_q;
    yin_start_d   = 1'b0;
    psola_start_d = 1'b0;
    frame_done_d  = 1'b0;
    unvoiced_d    = 1'b0;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    count_d       = count_q;
    bank_swap     = 1'b0;
    timer_expired = (timer_q == TW'(TIMEOUT - 1));

    if (bank_full && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bank_full) begin
          bank_swap   = 1'b1;
          rd_bank_d   = fill_bank;
          yin_start_d = 1'b1;
          state_d     = ST_ANALYZE;
          timer_d     = '0;
        end
      end
      ST_ANALYZE: begin
        // A result arriving on the expiry cycle still counts
        if (yin_valid_in) begin
          timer_d = '0;
          if (taumin_in < PERIOD_W'(MIN_PERIOD)) begin
            unvoiced_d   = 1'b1;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            period_d      = taumin_in;
            psola_start_d = 1'b1;
            state_d       = ST_SYNTH;
          end
        end else if (timer_expired) begin
          timeout_d    = 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = '0;
        end
      end
      ST_SYNTH: begin
        if (psola_done_in) begin
          frame_done_d = 1'b1;
          count_d      = count_q + 1'b1;
          state_d      = ST_IDLE;
          timer_d      = '0;
        end else if (timer_expired) begin
          timeout_d    = 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // FSM, timer and status registers; the read bank starts opposite the fill bank
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      rd_bank_q     <= 1'b1;
      period_q      <= '0;
      yin_start_q   <= 1'b0;
      psola_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      unvoiced_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rd_bank_q     <= rd_bank_d;
      period_q      <= period_d;
      yin_start_q   <= yin_start_d;
      psola_start_q <= psola_start_d;
      frame_done_q  <= frame_done_d;
      unvoiced_q    <= unvoiced_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
    end
  end

  assign rd_bank_out     = rd_bank_q;
  assign yin_start_out   = yin_start_q;
  assign psola_start_out = psola_start_q;
  assign period_out      = period_q;
  assign frame_done_out  = frame_done_q;
  assign unvoiced_out    = unvoiced_q;
  assign overrun_out     = overrun_q;
  assign timeout_out     = timeout_q;
  assign frame_count_out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pitch_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pitch_frame_scheduler                               |
// | Description : Directed bench for pitch_frame_scheduler with a short  |
// |               window and a short timeout.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pitch_frame_scheduler;

  localparam int WIDTH = 16;
  localparam int WS    = 16;
  localparam int AW    = 4;
  localparam int MINP  = 20;
  localparam int TO    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  sample = '0;
  logic              valid = 1'b0;
  logic              wr_en;
  logic [AW:0]       wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_bank;
  logic              yin_start;
  logic              yin_valid = 1'b0;
  logic [10:0]       taumin = '0;
  logic              psola_start;
  logic [10:0]       period;
  logic              psola_done = 1'b0;
  logic              frame_done;
  logic              unvoiced;
  logic              overrun;
  logic              timeout;
  logic [15:0]       frame_count;

  always #5 clk = ~clk;

  pitch_frame_scheduler #(
    .WIDTH       (WIDTH),
    .WINDOW_SIZE (WS),
    .MIN_PERIOD  (MINP),
    .TIMEOUT     (TO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sample_in       (sample),
    .valid_in        (valid),
    .wr_en_out       (wr_en),
    .wr_addr_out     (wr_addr),
    .wr_data_out     (wr_data),
    .rd_bank_out     (rd_bank),
    .yin_start_out   (yin_start),
    .yin_valid_in    (yin_valid),
    .taumin_in       (taumin),
    .psola_start_out (psola_start),
    .period_out      (period),
    .psola_done_in   (psola_done),
    .frame_done_out  (frame_done),
    .unvoiced_out    (unvoiced),
    .overrun_out     (overrun),
    .timeout_out     (timeout),
    .frame_count_out (frame_count)
  );

  typedef struct {
    logic [10:0] tau;
    bit          voiced;
  } vec_t;

  vec_t        vecs [6];
  int          total = 0;
  int          bad   = 0;
  int          m_fill, m_idx, m_rd, m_count;
  logic [10:0] m_period;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input bit chk);
    valid  = 1'b1;
    sample = d;
    tick();
    valid  = 1'b0;
    if (chk) begin
      check("wr_en", {31'd0, wr_en}, 32'd1);
      check("wr_addr", {27'd0, wr_addr}, (m_fill << AW) | m_idx);
      check("wr_data", {16'd0, wr_data}, {16'd0, d});
    end
    m_idx = (m_idx + 1) % WS;
  endtask

  // Completes the current fill bank with the FSM idle and checks the hand-off
  task automatic fill_to_full;
    int n;
    n = WS - m_idx;
    for (int i = 0; i < n; i++) push(16'(i + 7), 1'b0);
    tick();
    check("yin_start", {31'd0, yin_start}, 32'd1);
    check("rd_bank", {31'd0, rd_bank}, m_fill);
    m_rd   = m_fill;
    m_fill = m_fill ^ 1;
  endtask

  task automatic pulse_yin(input logic [10:0] t);
    yin_valid = 1'b1;
    taumin    = t;
    tick();
    yin_valid = 1'b0;
  endtask

  task automatic finish_synth;
    psola_done = 1'b1;
    tick();
    psola_done = 1'b0;
    check("frame_done", {31'd0, frame_done}, 32'd1);
    m_count++;
    check("frame_count", {16'd0, frame_count}, m_count);
    tick();
    check("frame_done_width", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic check_reset_state;
    check("rst_wr", {31'd0, wr_en} | {27'd0, wr_addr} | {16'd0, wr_data}, 32'd0);
    check("rst_rd_bank", {31'd0, rd_bank}, 32'd1);
    check("rst_pulses", {28'd0, yin_start, psola_start, frame_done, unvoiced}, 32'd0);
    check("rst_period", {21'd0, period}, 32'd0);
    check("rst_sticky", {30'd0, overrun, timeout}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic early;
    vecs[0] = '{11'd100,  1'b1};
    vecs[1] = '{11'd5,    1'b0};
    vecs[2] = '{11'd19,   1'b0};
    vecs[3] = '{11'd20,   1'b1};
    vecs[4] = '{11'd0,    1'b0};
    vecs[5] = '{11'd2047, 1'b1};

    m_fill = 0; m_idx = 0; m_rd = 1; m_count = 0; m_period = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state();

    // First bank fills with sample = index, swap cycle write goes to the new bank
    for (int i = 0; i < WS; i++) push(16'(i), 1'b1);
    valid  = 1'b1;
    sample = 16'hABCD;
    tick();
    valid  = 1'b0;
    check("t1_yin_start", {31'd0, yin_start}, 32'd1);
    check("t1_rd_bank", {31'd0, rd_bank}, 32'd0);
    check("t1_next_addr", {27'd0, wr_addr}, (1 << AW));
    m_fill = 1; m_idx = 1; m_rd = 0;
    tick();
    check("t1_yin_width", {31'd0, yin_start}, 32'd0);

    // Voiced analysis then synthesis
    pulse_yin(11'd100);
    check("t2_psola_start", {31'd0, psola_start}, 32'd1);
    check("t2_period", {21'd0, period}, 32'd100);
    m_period = 11'd100;
    tick();
    check("t2_psola_width", {31'd0, psola_start}, 32'd0);
    finish_synth();

    // Strobes are ignored in IDLE
    yin_valid = 1'b1; taumin = 11'd200; psola_done = 1'b1;
    tick();
    yin_valid = 1'b0; psola_done = 1'b0;
    check("idle_filter", {29'd0, yin_start, psola_start, frame_done}, 32'd0);
    check("idle_count", {16'd0, frame_count}, m_count);
    check("idle_period", {21'd0, period}, {21'd0, m_period});

    // Table of analysis outcomes, including the MIN_PERIOD boundary
    for (int v = 0; v < 6; v++) begin
      fill_to_full();
      pulse_yin(vecs[v].tau);
      check("vec_psola_start", {31'd0, psola_start}, {31'd0, vecs[v].voiced});
      check("vec_unvoiced", {31'd0, unvoiced}, {31'd0, !vecs[v].voiced});
      check("vec_frame_done", {31'd0, frame_done}, {31'd0, !vecs[v].voiced});
      if (vecs[v].voiced) m_period = vecs[v].tau;
      check("vec_period", {21'd0, period}, {21'd0, m_period});
      if (vecs[v].voiced) begin
        tick();
        finish_synth();
      end else begin
        check("vec_count_hold", {16'd0, frame_count}, m_count);
        tick();
        check("vec_unvoiced_width", {31'd0, unvoiced}, 32'd0);
      end
    end

    // Overrun while psola is busy
    fill_to_full();
    pulse_yin(11'd100);
    tick();
    for (int i = 0; i < WS; i++) push(16'(i), 1'b0);
    tick();
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_no_start", {31'd0, yin_start}, 32'd0);
    check("ovr_rd_bank", {31'd0, rd_bank}, m_rd);
    push(16'h0055, 1'b1);
    finish_synth();

    // Analysis timeout
    fill_to_full();
    early = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      early = early | frame_done | timeout;
    end
    check("to_early", {31'd0, early}, 32'd0);
    tick();
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_frame_done", {31'd0, frame_done}, 32'd1);
    check("to_count", {16'd0, frame_count}, m_count);
    tick();

    // Next bank starts normally; yin result on the expiry cycle wins
    fill_to_full();
    repeat (TO - 1) tick();
    pulse_yin(11'd5);
    check("expiry_unvoiced", {31'd0, unvoiced}, 32'd1);
    check("expiry_frame_done", {31'd0, frame_done}, 32'd1);
    tick();

    // Reset in SYNTH with valid and psola_done in the same cycle
    fill_to_full();
    pulse_yin(11'd100);
    tick();
    rst = 1'b1; valid = 1'b1; psola_done = 1'b1; sample = 16'hFFFF;
    tick();
    rst = 1'b0; valid = 1'b0; psola_done = 1'b0;
    check_reset_state();
    m_fill = 0; m_idx = 0; m_rd = 1; m_count = 0; m_period = '0;
    push(16'h1234, 1'b1);

    // Bank full on the cycle SYNTH completes is an overrun
    fill_to_full();
    pulse_yin(11'd100);
    tick();
    for (int i = 0; i < WS; i++) push(16'(i), 1'b0);
    psola_done = 1'b1;
    tick();
    psola_done = 1'b0;
    check("same_frame_done", {31'd0, frame_done}, 32'd1);
    check("same_overrun", {31'd0, overrun}, 32'd1);
    check("same_no_start", {31'd0, yin_start}, 32'd0);
    tick();
    check("same_no_late_start", {31'd0, yin_start}, 32'd0);
    check("same_count", {16'd0, frame_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
